// File: rtl/pass_sched_pkg.sv
// Shared constants and encodings for the layer-level pass scheduler.
// ID table geometry follows the PE array size.
package pass_sched_pkg;

    localparam int NUMS_PE_ROW    = 6;
    localparam int NUMS_PE_COL    = 8;
    localparam int ID_XID_ENTRIES = NUMS_PE_ROW * NUMS_PE_COL;
    localparam int ID_YID_ENTRIES = NUMS_PE_ROW;
    localparam int ID_TABLE_DEPTH = 4 * (ID_XID_ENTRIES + ID_YID_ENTRIES);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_ID    = 3'd1,
        ST_LOAD_DRAIN = 3'd2,
        ST_SETUP      = 3'd3,
        ST_RUN        = 3'd4,
        ST_RELEASE    = 3'd5,
        ST_ADVANCE    = 3'd6,
        ST_FINISH     = 3'd7
    } sched_state_e;

    typedef enum logic [2:0] {
        WSEL_IFMAP_X  = 3'd0,
        WSEL_FILTER_X = 3'd1,
        WSEL_IPSUM_X  = 3'd2,
        WSEL_OPSUM_X  = 3'd3,
        WSEL_IFMAP_Y  = 3'd4,
        WSEL_FILTER_Y = 3'd5,
        WSEL_IPSUM_Y  = 3'd6,
        WSEL_OPSUM_Y  = 3'd7
    } id_wsel_e;

endpackage

// File: rtl/pass_scheduler_id_table_loader.sv
// Streams the flat ID memory (XID tables then YID tables) into the pass
// controller's ID write port, one entry per cycle, writes trailing reads by one cycle.
module id_table_loader
    import pass_sched_pkg::*;
#(
    parameter int XID_BITS = 8,
    parameter int YID_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                done,
    output logic                id_rd_en,
    output logic [7:0]          id_rd_addr,
    input  logic [XID_BITS-1:0] id_rd_data,
    output logic                ctrl_ID_wen,
    output logic [2:0]          ctrl_ID_wsel,
    output logic [5:0]          ctrl_ID_widx,
    output logic [XID_BITS-1:0] ctrl_ID_wdata
);

    localparam logic [7:0] LAST_ADDR  = 8'(ID_TABLE_DEPTH - 1);
    localparam logic [5:0] X_LAST_IDX = 6'(ID_XID_ENTRIES - 1);
    localparam logic [5:0] Y_LAST_IDX = 6'(ID_YID_ENTRIES - 1);
    localparam logic [XID_BITS-1:0] Y_MASK = XID_BITS'((64'd1 << YID_BITS) - 64'd1);

    logic                rd_en_q;
    logic [7:0]          rd_addr_q;
    logic [2:0]          rd_sel_q;
    logic [5:0]          rd_idx_q;
    logic                wen_q;
    logic [2:0]          wsel_q;
    logic [5:0]          widx_q;
    logic [5:0]          idx_last_s;
    logic                last_rd_s;
    logic [XID_BITS-1:0] wdata_s;

    assign last_rd_s = rd_en_q && (rd_addr_q == LAST_ADDR);

    // Selects the final index of the table being read; YID tables are shorter.
    always_comb begin
        if (rd_sel_q[2]) begin
            idx_last_s = Y_LAST_IDX;
        end else begin
            idx_last_s = X_LAST_IDX;
        end
    end

    // Read side: flat address and its (sel, idx) split advance together, no division needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= 8'd0;
            rd_sel_q  <= 3'd0;
            rd_idx_q  <= 6'd0;
        end else if (start) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= 8'd0;
            rd_sel_q  <= 3'd0;
            rd_idx_q  <= 6'd0;
        end else if (last_rd_s) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= 8'd0;
            rd_sel_q  <= 3'd0;
            rd_idx_q  <= 6'd0;
        end else if (rd_en_q) begin
            rd_addr_q <= rd_addr_q + 8'd1;
            if (rd_idx_q == idx_last_s) begin
                rd_idx_q <= 6'd0;
                rd_sel_q <= rd_sel_q + 3'd1;
            end else begin
                rd_idx_q <= rd_idx_q + 6'd1;
            end
        end else begin
            rd_en_q <= 1'b0;
        end
    end

    // Write side: the table coordinates of each read are replayed one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q  <= 1'b0;
            wsel_q <= 3'd0;
            widx_q <= 6'd0;
        end else if (rd_en_q) begin
            wen_q  <= 1'b1;
            wsel_q <= rd_sel_q;
            widx_q <= rd_idx_q;
        end else begin
            wen_q  <= 1'b0;
            wsel_q <= 3'd0;
            widx_q <= 6'd0;
        end
    end

    // Read data lands in the same cycle as its write strobe; YID entries keep only YID_BITS.
    always_comb begin
        if (!wen_q) begin
            wdata_s = '0;
        end else if (wsel_q[2]) begin
            wdata_s = id_rd_data & Y_MASK;
        end else begin
            wdata_s = id_rd_data;
        end
    end

    assign done          = last_rd_s;
    assign id_rd_en      = rd_en_q;
    assign id_rd_addr    = rd_addr_q;
    assign ctrl_ID_wen   = wen_q;
    assign ctrl_ID_wsel  = wsel_q;
    assign ctrl_ID_widx  = widx_q;
    assign ctrl_ID_wdata = wdata_s;

endmodule

// File: rtl/pass_scheduler.sv
// Layer-level scheduler: loads PE ID tables, then sequences M x C passes of the
// pass controller with adder-only base address generation.
module pass_scheduler
    import pass_sched_pkg::*;
#(
    parameter int XID_BITS = 8,
    parameter int YID_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [31:0]         cmd_op_config,
    input  logic [31:0]         cmd_mapping_param,
    input  logic [31:0]         cmd_shape_param1,
    input  logic [31:0]         cmd_shape_param2,
    input  logic [31:0]         cmd_filter_region,
    input  logic [31:0]         cmd_ifmap_region,
    input  logic [31:0]         cmd_bias_region,
    input  logic [31:0]         cmd_opsum_region,
    input  logic [31:0]         cmd_filter_stride,
    input  logic [31:0]         cmd_ifmap_stride,
    input  logic [31:0]         cmd_bias_stride,
    input  logic [31:0]         cmd_opsum_stride,
    input  logic [7:0]          cmd_m_groups,
    input  logic [7:0]          cmd_c_groups,
    output logic                id_rd_en,
    output logic [7:0]          id_rd_addr,
    input  logic [XID_BITS-1:0] id_rd_data,
    output logic                ctrl_ID_wen,
    output logic [2:0]          ctrl_ID_wsel,
    output logic [5:0]          ctrl_ID_widx,
    output logic [XID_BITS-1:0] ctrl_ID_wdata,
    output logic [31:0]         op_config,
    output logic [31:0]         mapping_param,
    output logic [31:0]         shape_param1,
    output logic [31:0]         shape_param2,
    output logic [31:0]         filter_baseaddr,
    output logic [31:0]         ifmap_baseaddr,
    output logic [31:0]         bias_baseaddr,
    output logic [31:0]         opsum_baseaddr,
    output logic                bias_ipsum_sel,
    input  logic                pass_done,
    output logic                busy,
    output logic                layer_done
);

    sched_state_e state_q;
    logic        cmd_ready_q;
    logic [31:0] op_cfg_q, mapping_q, shape1_q, shape2_q;
    logic [31:0] ifmap_region_q;
    logic [31:0] filter_stride_q, ifmap_stride_q, bias_stride_q, opsum_stride_q;
    logic [7:0]  m_groups_q, c_groups_q, m_idx_q, c_idx_q;
    logic [31:0] filter_ptr_q, ifmap_ptr_q, bias_ptr_q, opsum_ptr_q;
    logic        accept_s, load_start_s, load_done_s, last_c_s, last_pass_s;

    assign accept_s     = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;
    assign load_start_s = accept_s && (cmd_m_groups != 8'd0) && (cmd_c_groups != 8'd0);
    assign last_c_s     = (c_idx_q == c_groups_q - 8'd1);
    assign last_pass_s  = last_c_s && (m_idx_q == m_groups_q - 8'd1);

    id_table_loader #(
        .XID_BITS (XID_BITS),
        .YID_BITS (YID_BITS)
    ) u_loader (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (load_start_s),
        .done          (load_done_s),
        .id_rd_en      (id_rd_en),
        .id_rd_addr    (id_rd_addr),
        .id_rd_data    (id_rd_data),
        .ctrl_ID_wen   (ctrl_ID_wen),
        .ctrl_ID_wsel  (ctrl_ID_wsel),
        .ctrl_ID_widx  (ctrl_ID_widx),
        .ctrl_ID_wdata (ctrl_ID_wdata)
    );

    // Layer FSM: command latch, pass sequencing and pointer advance (m outer, c inner).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cmd_ready_q     <= 1'b0;
            op_cfg_q        <= 32'd0;
            mapping_q       <= 32'd0;
            shape1_q        <= 32'd0;
            shape2_q        <= 32'd0;
            ifmap_region_q  <= 32'd0;
            filter_stride_q <= 32'd0;
            ifmap_stride_q  <= 32'd0;
            bias_stride_q   <= 32'd0;
            opsum_stride_q  <= 32'd0;
            m_groups_q      <= 8'd0;
            c_groups_q      <= 8'd0;
            m_idx_q         <= 8'd0;
            c_idx_q         <= 8'd0;
            filter_ptr_q    <= 32'd0;
            ifmap_ptr_q     <= 32'd0;
            bias_ptr_q      <= 32'd0;
            opsum_ptr_q     <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept_s) begin
                        cmd_ready_q     <= 1'b0;
                        op_cfg_q        <= cmd_op_config;
                        mapping_q       <= cmd_mapping_param;
                        shape1_q        <= cmd_shape_param1;
                        shape2_q        <= cmd_shape_param2;
                        ifmap_region_q  <= cmd_ifmap_region;
                        filter_stride_q <= cmd_filter_stride;
                        ifmap_stride_q  <= cmd_ifmap_stride;
                        bias_stride_q   <= cmd_bias_stride;
                        opsum_stride_q  <= cmd_opsum_stride;
                        m_groups_q      <= cmd_m_groups;
                        c_groups_q      <= cmd_c_groups;
                        m_idx_q         <= 8'd0;
                        c_idx_q         <= 8'd0;
                        filter_ptr_q    <= cmd_filter_region;
                        ifmap_ptr_q     <= cmd_ifmap_region;
                        bias_ptr_q      <= cmd_bias_region;
                        opsum_ptr_q     <= cmd_opsum_region;
                        state_q         <= load_start_s ? ST_LOAD_ID : ST_FINISH;
                    end
                end
                ST_LOAD_ID: begin
                    if (load_done_s) begin
                        state_q <= ST_LOAD_DRAIN;
                    end
                end
                ST_LOAD_DRAIN: state_q <= ST_SETUP;
                ST_SETUP:      state_q <= ST_RUN;
                ST_RUN: begin
                    if (pass_done) begin
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!pass_done) begin
                        state_q <= last_pass_s ? ST_FINISH : ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    filter_ptr_q <= filter_ptr_q + filter_stride_q;
                    if (!last_c_s) begin
                        c_idx_q     <= c_idx_q + 8'd1;
                        ifmap_ptr_q <= ifmap_ptr_q + ifmap_stride_q;
                    end else begin
                        c_idx_q     <= 8'd0;
                        ifmap_ptr_q <= ifmap_region_q;
                        m_idx_q     <= m_idx_q + 8'd1;
                        bias_ptr_q  <= bias_ptr_q + bias_stride_q;
                        opsum_ptr_q <= opsum_ptr_q + opsum_stride_q;
                    end
                    state_q <= ST_SETUP;
                end
                ST_FINISH: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    cmd_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Bit 0 of the latched config is replaced by the pass start strobe.
    assign op_config       = (op_cfg_q & ~32'd1) | {31'd0, (state_q == ST_RUN)};
    assign cmd_ready       = cmd_ready_q;
    assign mapping_param   = mapping_q;
    assign shape_param1    = shape1_q;
    assign shape_param2    = shape2_q;
    assign filter_baseaddr = filter_ptr_q;
    assign ifmap_baseaddr  = ifmap_ptr_q;
    assign bias_baseaddr   = bias_ptr_q;
    assign opsum_baseaddr  = opsum_ptr_q;
    assign bias_ipsum_sel  = (state_q != ST_IDLE) && (c_idx_q == 8'd0);
    assign busy            = (state_q != ST_IDLE);
    assign layer_done      = (state_q == ST_FINISH);

endmodule
